// File: rtl/sm3_pad_pkg.sv
// SM3 padder shared types and helpers.
// Word geometry, state encoding and last-beat mask/marker logic.
package sm3_pad_pkg;

  typedef enum logic [1:0] {
    DATA,
    MARK,
    ZERO,
    LEN
  } state_e;

  typedef logic [63:0] len_t;

  function automatic int wpb(input int dw);
    return 512 / dw;
  endfunction

  function automatic int lslot(input int dw);
    return 512 / dw - 64 / dw;
  endfunction

  // d and vb are left-justified in 64/8 bits; the first
  // disabled byte after an enabled run receives 0x80.
  function automatic logic [63:0] last_word(
    input logic [63:0] d,
    input logic [7:0]  vb
  );
    logic [63:0] r;
    logic        prev;
    r    = '0;
    prev = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (vb[7-i])
        r[63-8*i -: 8] = d[63-8*i -: 8];
      else if (prev)
        r[63-8*i -: 8] = 8'h80;
      prev = vb[7-i];
    end
    return r;
  endfunction

  function automatic logic [3:0] nbytes(input logic [7:0] vb);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++)
      n = n + {3'b000, vb[i]};
    return n;
  endfunction

endpackage

// File: rtl/sm3_pad_dw.sv
// SM3 message padder, 32- or 64-bit words.
// Emits data, 0x80 marker, zero fill and 64-bit bit length.
module sm3_pad_dw
  import sm3_pad_pkg::*;
#(
  parameter int DW    = 32,
  parameter int LEN_W = 61
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW-1:0]   msg_inpt_d,
  input  logic [DW/8-1:0] msg_inpt_vld_byte,
  input  logic            msg_inpt_vld,
  input  logic            msg_inpt_lst,
  output logic            msg_inpt_rdy,
  input  logic            pad_otpt_ena,
  output logic [DW-1:0]   pad_otpt_d,
  output logic            pad_otpt_vld,
  output logic            pad_otpt_blk_end,
  output logic            pad_otpt_lst
);

  localparam int NB    = DW / 8;
  localparam int WPB   = wpb(DW);
  localparam int LW    = 64 / DW;
  localparam int LSLOT = lslot(DW);
  localparam int WI_W  = $clog2(WPB);

  localparam logic [WI_W-1:0] WLAST  = WI_W'(WPB - 1);
  localparam logic [WI_W-1:0] WLSLOT = WI_W'(LSLOT);
  localparam logic [DW-1:0]   MARK_W = {8'h80, {(DW-8){1'b0}}};
  localparam logic            ONE_LW = (LW == 1);

  if (DW != 32 && DW != 64) begin : g_bad_dw
    $error("sm3_pad_dw: DW must be 32 or 64");
  end

  state_e          state_q;
  logic [LEN_W-1:0] cnt_q;
  logic [WI_W-1:0] widx_q;
  logic            init_q;
  logic [DW-1:0]   d_q;
  logic            vld_q;
  logic            blk_q;
  logic            lst_q;

  logic            can_load;
  logic            in_fire;
  logic            full;
  len_t            len64;
  logic [DW-1:0]   tail_w;
  logic [DW-1:0]   len_hi;
  logic [DW-1:0]   len_lo;
  logic            ld;
  logic [DW-1:0]   ld_w;
  logic            ld_lst;

  assign can_load     = !vld_q || pad_otpt_ena;
  assign msg_inpt_rdy = init_q && (state_q == DATA) && can_load;
  assign in_fire      = msg_inpt_vld && msg_inpt_rdy;
  assign full         = &msg_inpt_vld_byte;

  assign tail_w = DW'(last_word(
    64'(msg_inpt_d) << (64 - DW),
    8'(msg_inpt_vld_byte) << (8 - NB)
  ) >> (64 - DW));

  assign len64  = len_t'({cnt_q, 3'b000});
  assign len_hi = DW'(len64 >> (64 - DW));
  assign len_lo = DW'(len64);

  always_comb begin
    ld     = 1'b0;
    ld_w   = '0;
    ld_lst = 1'b0;
    if (can_load) begin
      unique case (state_q)
        DATA: begin
          ld   = in_fire;
          ld_w = msg_inpt_lst ? tail_w : msg_inpt_d;
        end
        MARK: begin
          ld   = 1'b1;
          ld_w = MARK_W;
        end
        ZERO: begin
          ld = 1'b1;
          if (widx_q == WLSLOT) begin
            ld_w   = len_hi;
            ld_lst = ONE_LW;
          end
        end
        LEN: begin
          ld     = 1'b1;
          ld_w   = len_lo;
          ld_lst = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DATA;
      cnt_q   <= '0;
      widx_q  <= '0;
      init_q  <= 1'b0;
      d_q     <= '0;
      vld_q   <= 1'b0;
      blk_q   <= 1'b0;
      lst_q   <= 1'b0;
    end else begin
      init_q <= 1'b1;
      if (vld_q && pad_otpt_ena)
        vld_q <= 1'b0;
      if (ld) begin
        d_q    <= ld_w;
        vld_q  <= 1'b1;
        blk_q  <= (widx_q == WLAST);
        lst_q  <= ld_lst;
        widx_q <= widx_q + 1'b1;
        unique case (state_q)
          DATA: begin
            if (msg_inpt_lst) begin
              cnt_q   <= cnt_q + LEN_W'(nbytes(
                8'(msg_inpt_vld_byte) << (8 - NB)));
              state_q <= full ? MARK : ZERO;
            end else begin
              cnt_q <= cnt_q + LEN_W'(NB);
            end
          end
          MARK: state_q <= ZERO;
          ZERO: begin
            if (widx_q == WLSLOT) begin
              if (ONE_LW) begin
                cnt_q   <= '0;
                widx_q  <= '0;
                state_q <= DATA;
              end else begin
                state_q <= LEN;
              end
            end
          end
          LEN: begin
            cnt_q   <= '0;
            widx_q  <= '0;
            state_q <= DATA;
          end
          default: state_q <= DATA;
        endcase
      end
    end
  end

  assign pad_otpt_d       = d_q;
  assign pad_otpt_vld     = vld_q;
  assign pad_otpt_blk_end = blk_q;
  assign pad_otpt_lst     = lst_q;

endmodule
